// File: rtl/qosc_reg_pkg.sv
// ============================================================================
// Module  : qosc_reg_pkg
// Brief   : Shared definitions for the quadrature-oscillator register bank:
//           register index, CTRL/STATUS bit positions, unlock key and the
//           commit FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package qosc_reg_pkg;

   // Oscillator register order in the bank (also the address-map order)
   typedef enum logic [2:0] {
      REG_INIT_RE  = 3'd0,
      REG_INIT_IM  = 3'd1,
      REG_RE_COEFF = 3'd2,
      REG_IM_COEFF = 3'd3,
      REG_POWER    = 3'd4
   } reg_idx_e;

   localparam int N_REGS = 5;

   // CTRL write bits
   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_REVERT_BIT = 1;
   localparam int CTRL_LOCK_BIT   = 7;

   // STATUS read bits
   localparam int STAT_PENDING_BIT  = 0;
   localparam int STAT_DIRTY_BIT    = 1;
   localparam int STAT_LOCKED_BIT   = 2;
   localparam int STAT_ADDR_ERR_BIT = 3;

   localparam logic [7:0] UNLOCK_KEY = 8'hA5;

   // Commit FSM state encoding
   typedef logic [1:0] commit_state_t;
   localparam commit_state_t ST_IDLE    = 2'd0;
   localparam commit_state_t ST_PENDING = 2'd1;
   localparam commit_state_t ST_COPY    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/qosc_reg_commit_fsm.sv
// ============================================================================
// Module  : qosc_reg_commit_fsm
// Brief   : Sequences shadow->active commits. A request while the core holds
//           is parked in PENDING until hold drops; a revert cancels it.
//           commit_stb_o pulses the cycle the active bank shows new values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module qosc_reg_commit_fsm
   import qosc_reg_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic hold_i,
   input  logic req_i,
   input  logic revert_i,
   output logic copy_en_o,
   output logic commit_stb_o,
   output logic pending_o
);

   commit_state_t state_q, state_d;
   logic          stb_q;

   // Next-state logic; requests arriving in PENDING/COPY are absorbed
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i) state_d = hold_i ? ST_PENDING : ST_COPY;
         end
         ST_PENDING: begin
            if (revert_i)     state_d = ST_IDLE;
            else if (!hold_i) state_d = ST_COPY;
         end
         ST_COPY:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register; strobe follows the COPY cycle so it aligns with new data
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stb_q   <= (state_q == ST_COPY);
      end
   end

   assign copy_en_o    = (state_q == ST_COPY);
   assign pending_o    = (state_q == ST_PENDING);
   assign commit_stb_o = stb_q;

endmodule

`default_nettype wire

// File: rtl/qosc_reg_bank.sv
// ============================================================================
// Module  : qosc_reg_bank
// Brief   : Byte-bus shadow/active register bank for the quadrature
//           oscillator. Address 0 is CTRL/STATUS; register k byte b sits at
//           1 + k*NB + b. Readback (of the shadow bank) has 1-cycle latency.
//           Optional write lock: define QOSC_REG_LOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module qosc_reg_bank
   import qosc_reg_pkg::*;
#(
   parameter int               REG_W   = 16,
   parameter int               ADDR_W  = 5,
   parameter logic [REG_W-1:0] RST_RE0 = 'h0020,
   parameter logic [REG_W-1:0] RST_IM0 = 'h0000,
   parameter logic [REG_W-1:0] RST_RC  = 'h007d,
   parameter logic [REG_W-1:0] RST_IC  = 'h001b,
   parameter logic [REG_W-1:0] RST_PWR = 'h0010
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] address_i,
   input  logic [7:0]        data_in_i,
   output logic [7:0]        rd_data_o,
   output logic              rd_valid_o,
   input  logic              hold_i,
   output logic              commit_stb_o,
   output logic [REG_W-1:0]  init_re_o,
   output logic [REG_W-1:0]  init_im_o,
   output logic [REG_W-1:0]  re_coeff_o,
   output logic [REG_W-1:0]  im_coeff_o,
   output logic [REG_W-1:0]  power_o
);

   localparam int NB     = REG_W / 8;
   localparam int NBYTES = N_REGS * NB;
   localparam int BANK_W = N_REGS * REG_W;

   // Flat bank: byte j of the vector is data address j+1
   localparam logic [BANK_W-1:0] RST_BANK = {RST_PWR, RST_IC, RST_RC, RST_IM0, RST_RE0};

   logic [BANK_W-1:0] shadow_q, shadow_d;
   logic [BANK_W-1:0] active_q;
   logic              dirty_q, dirty_d;
   logic              err_q, err_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              rd_valid_q;

   logic              is_ctrl, in_range;
   logic [ADDR_W-1:0] byte_idx;
   logic              ctrl_wr, key_wr, locked;
   logic              commit_req, revert_req, data_wr, wr_err, rd_err;
   logic              copy_en, pending;
   logic [7:0]        status;

   assign is_ctrl  = (address_i == '0);
   assign in_range = (address_i <= ADDR_W'(NBYTES));
   assign byte_idx = address_i - ADDR_W'(1);
   assign ctrl_wr  = wr_en_i & is_ctrl;

`ifdef QOSC_REG_LOCK_EN
   logic locked_q, locked_d;

   assign key_wr = ctrl_wr & (data_in_i == UNLOCK_KEY);

   // Lock flag: the key only unlocks; any other CTRL write with bit7 locks
   always_comb begin
      locked_d = locked_q;
      if (key_wr)                                 locked_d = 1'b0;
      else if (ctrl_wr && data_in_i[CTRL_LOCK_BIT]) locked_d = 1'b1;
   end

   // Lock register
   always_ff @(posedge clk_i) begin
      if (reset_i) locked_q <= 1'b0;
      else         locked_q <= locked_d;
   end

   assign locked = locked_q;
`else
   assign key_wr = 1'b0;
   assign locked = 1'b0;
`endif

   // Revert has priority over commit when both bits are set
   assign commit_req = ctrl_wr & ~key_wr & ~locked
                     & data_in_i[CTRL_COMMIT_BIT] & ~data_in_i[CTRL_REVERT_BIT];
   assign revert_req = ctrl_wr & ~key_wr & ~locked & data_in_i[CTRL_REVERT_BIT];
   assign data_wr    = wr_en_i & ~is_ctrl & in_range & ~locked;
   assign wr_err     = wr_en_i & ~is_ctrl & (~in_range | locked);
   assign rd_err     = rd_en_i & ~in_range;

   qosc_reg_commit_fsm u_commit_fsm (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .hold_i       (hold_i),
      .req_i        (commit_req),
      .revert_i     (revert_req),
      .copy_en_o    (copy_en),
      .commit_stb_o (commit_stb_o),
      .pending_o    (pending)
   );

   // STATUS byte assembly
   always_comb begin
      status                    = '0;
      status[STAT_PENDING_BIT]  = pending;
      status[STAT_DIRTY_BIT]    = dirty_q;
      status[STAT_LOCKED_BIT]   = locked;
      status[STAT_ADDR_ERR_BIT] = err_q;
   end

   // Shadow update, dirty and sticky error tracking
   always_comb begin
      shadow_d = shadow_q;
      if (revert_req) begin
         shadow_d = active_q;
      end else if (data_wr) begin
         for (int j = 0; j < NBYTES; j++) begin
            if (byte_idx == ADDR_W'(j)) shadow_d[j*8 +: 8] = data_in_i;
         end
      end

      // A write landing in the COPY cycle is not copied, so it leaves dirty set
      dirty_d = dirty_q;
      if (copy_en || revert_req) dirty_d = 1'b0;
      if (data_wr)               dirty_d = 1'b1;

      // Clear-on-read loses to an error raised in the same cycle
      err_d = err_q;
      if (rd_en_i && is_ctrl) err_d = 1'b0;
      if (wr_err || rd_err)   err_d = 1'b1;
   end

   // Readback mux from pre-write shadow contents
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) begin
         if (is_ctrl) begin
            rd_data_d = status;
         end else begin
            rd_data_d = '0;
            for (int j = 0; j < NBYTES; j++) begin
               if (in_range && byte_idx == ADDR_W'(j)) rd_data_d = shadow_q[j*8 +: 8];
            end
         end
      end
   end

   // Bank, status and readback registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         shadow_q   <= RST_BANK;
         active_q   <= RST_BANK;
         dirty_q    <= 1'b0;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         if (copy_en) active_q <= shadow_q;
         dirty_q    <= dirty_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_en_i;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign init_re_o  = active_q[int'(REG_INIT_RE)  * REG_W +: REG_W];
   assign init_im_o  = active_q[int'(REG_INIT_IM)  * REG_W +: REG_W];
   assign re_coeff_o = active_q[int'(REG_RE_COEFF) * REG_W +: REG_W];
   assign im_coeff_o = active_q[int'(REG_IM_COEFF) * REG_W +: REG_W];
   assign power_o    = active_q[int'(REG_POWER)    * REG_W +: REG_W];

endmodule

`default_nettype wire
